// File: rtl/mu_bus_bridge.sv
// CPU-side front end for the MemoryUnit: single-access req/ack bridge with init gating and timeout abort.
// Latency: request edge -> mu_start next cycle; ack one cycle after busy is first sampled low (min 4 cycles).
// Backpressure: one outstanding access; cpu_req is only sampled in IDLE, so the CPU holds it until cpu_ack.
module mu_bus_bridge #(
    parameter int TIMEOUT = 4095,
    parameter int TW      = 12
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [26:0] cpu_addr,
    input  logic [31:0] cpu_data,
    output logic        cpu_ack,
    output logic [31:0] cpu_q,
    output logic        cpu_err,
    output logic        err_sticky,
    output logic        ready,
    output logic [26:0] mu_address,
    output logic [31:0] mu_data,
    output logic        mu_we,
    output logic        mu_start,
    input  logic        mu_initDone,
    input  logic        mu_busy,
    input  logic [31:0] mu_q
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_ACK
    } state_t;

    localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT);

    state_t        r_state;
    logic [TW-1:0] r_cnt;
    logic          r_cpu_ack;
    logic [31:0]   r_cpu_q;
    logic          r_cpu_err;
    logic          r_err_sticky;
    logic          r_ready;
    logic [26:0]   r_mu_address;
    logic [31:0]   r_mu_data;
    logic          r_mu_we;
    logic          r_mu_start;
    logic          w_timeout;

    // The counter keeps running across both wait states, so the limit bounds the whole access.
    assign w_timeout = (r_cnt == TO_LIMIT);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state      <= S_INIT;
            r_cnt        <= '0;
            r_cpu_ack    <= 1'b0;
            r_cpu_q      <= '0;
            r_cpu_err    <= 1'b0;
            r_err_sticky <= 1'b0;
            r_ready      <= 1'b0;
            r_mu_address <= '0;
            r_mu_data    <= '0;
            r_mu_we      <= 1'b0;
            r_mu_start   <= 1'b0;
        end else begin
            r_cpu_ack  <= 1'b0;
            r_mu_start <= 1'b0;
            case (r_state)
                S_INIT: begin
                    if (mu_initDone) begin
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (cpu_req) begin
                        r_mu_address <= cpu_addr;
                        r_mu_data    <= cpu_data;
                        r_mu_we      <= cpu_we;
                        r_mu_start   <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (w_timeout) begin
                        r_cpu_q      <= '0;
                        r_cpu_err    <= 1'b1;
                        r_err_sticky <= 1'b1;
                        r_cpu_ack    <= 1'b1;
                        r_state      <= S_ACK;
                    end else if (mu_busy) begin
                        r_state <= S_WAIT_DONE;
                    end else begin
                        r_cnt <= r_cnt + TW'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (w_timeout) begin
                        r_cpu_q      <= '0;
                        r_cpu_err    <= 1'b1;
                        r_err_sticky <= 1'b1;
                        r_cpu_ack    <= 1'b1;
                        r_state      <= S_ACK;
                    end else if (!mu_busy) begin
                        r_cpu_q   <= mu_q;
                        r_cpu_err <= 1'b0;
                        r_cpu_ack <= 1'b1;
                        r_state   <= S_ACK;
                    end else begin
                        r_cnt <= r_cnt + TW'(1);
                    end
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_INIT;
                end
            endcase
        end
    end

    assign cpu_ack    = r_cpu_ack;
    assign cpu_q      = r_cpu_q;
    assign cpu_err    = r_cpu_err;
    assign err_sticky = r_err_sticky;
    assign ready      = r_ready;
    assign mu_address = r_mu_address;
    assign mu_data    = r_mu_data;
    assign mu_we      = r_mu_we;
    assign mu_start   = r_mu_start;

endmodule

// File: tb/tb_mu_bus_bridge.sv
// Bench for mu_bus_bridge: behavioural MemoryUnit, reference memory and a scoreboard monitor.
module tb_mu_bus_bridge;

    localparam int TIMEOUT = 8;

    typedef struct {
        logic        we;
        logic [26:0] addr;
        logic [31:0] data;
        logic [31:0] q;
        logic        err;
        logic        sticky;
        bit          to;
        bit          chained;
    } exp_t;

    logic        clk;
    logic        nreset;
    logic        cpu_req;
    logic        cpu_we;
    logic [26:0] cpu_addr;
    logic [31:0] cpu_data;
    logic        cpu_ack;
    logic [31:0] cpu_q;
    logic        cpu_err;
    logic        err_sticky;
    logic        ready;
    logic [26:0] mu_address;
    logic [31:0] mu_data;
    logic        mu_we;
    logic        mu_start;
    logic        mu_initDone;
    logic        mu_busy;
    logic [31:0] mu_q;

    int checks = 0;
    int failures = 0;

    exp_t start_q[$];
    exp_t ack_q[$];
    logic [31:0] ref_mem [logic [26:0]];
    logic [31:0] mu_mem  [logic [26:0]];
    logic        sticky_m = 1'b0;

    bit cfg_stuck = 1'b0;
    int cfg_dly = 0;
    int cfg_len = 1;

    mu_bus_bridge #(.TIMEOUT(TIMEOUT), .TW(4)) dut (
        .clk        (clk),
        .nreset     (nreset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_data   (cpu_data),
        .cpu_ack    (cpu_ack),
        .cpu_q      (cpu_q),
        .cpu_err    (cpu_err),
        .err_sticky (err_sticky),
        .ready      (ready),
        .mu_address (mu_address),
        .mu_data    (mu_data),
        .mu_we      (mu_we),
        .mu_start   (mu_start),
        .mu_initDone(mu_initDone),
        .mu_busy    (mu_busy),
        .mu_q       (mu_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // MemoryUnit model: busy rises cfg_dly edges after start, stays high cfg_len cycles, then q is valid.
    int          ph = 0;
    int          mcnt = 0;
    logic [26:0] m_addr;
    logic [31:0] m_data;
    logic        m_we;
    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            mu_busy <= 1'b0;
            mu_q    <= '0;
            ph = 0;
        end else begin
            case (ph)
                0: if (mu_start) begin
                    m_addr = mu_address;
                    m_data = mu_data;
                    m_we   = mu_we;
                    mu_q  <= $urandom;
                    if (!cfg_stuck) begin
                        if (cfg_dly == 0) begin
                            mu_busy <= 1'b1;
                            mcnt = cfg_len;
                            ph = 2;
                        end else begin
                            mcnt = cfg_dly;
                            ph = 1;
                        end
                    end
                end
                1: begin
                    mcnt--;
                    if (mcnt == 0) begin
                        mu_busy <= 1'b1;
                        mcnt = cfg_len;
                        ph = 2;
                    end
                end
                default: begin
                    mcnt--;
                    mu_q <= $urandom;
                    if (mcnt == 0) begin
                        mu_busy <= 1'b0;
                        if (m_we) begin
                            mu_mem[m_addr] = m_data;
                            mu_q <= m_data;
                        end else begin
                            mu_q <= mu_mem.exists(m_addr) ? mu_mem[m_addr] : {5'h1B, m_addr};
                        end
                        ph = 0;
                    end
                end
            endcase
        end
    end

    // Scoreboard monitor, sampling on the falling edge.
    int          cyc = 0;
    int          start_cyc = 0;
    int          last_busy_cyc = 0;
    int          last_ack_cyc = 0;
    int          start_cnt = 0;
    logic        prev_start = 1'b0;
    logic        prev_ack = 1'b0;
    logic [31:0] last_q = '0;
    bit          have_cur = 1'b0;
    exp_t        cur;
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (nreset) begin
            if (mu_busy) last_busy_cyc = cyc;
            if (mu_start) begin
                start_cnt++;
                chk("start_pulse_prev_low", 64'(prev_start), 64'(0));
                if (start_q.size() == 0) begin
                    chk("start_unexpected", 64'(1), 64'(0));
                end else begin
                    e = start_q.pop_front();
                    chk("mu_address", 64'(mu_address), 64'(e.addr));
                    chk("mu_data", 64'(mu_data), 64'(e.data));
                    chk("mu_we", 64'(mu_we), 64'(e.we));
                    if (e.chained) chk("b2b_start_gap", 64'(cyc - last_ack_cyc), 64'(2));
                    cur = e;
                    have_cur = 1'b1;
                    start_cyc = cyc;
                end
            end
            if (mu_busy && have_cur)
                chk("bus_stable", {mu_we, mu_address, mu_data}, {cur.we, cur.addr, cur.data});
            if (cpu_ack) begin
                chk("ack_pulse_prev_low", 64'(prev_ack), 64'(0));
                if (ack_q.size() == 0) begin
                    chk("ack_unexpected", 64'(1), 64'(0));
                end else begin
                    e = ack_q.pop_front();
                    chk("cpu_q", 64'(cpu_q), 64'(e.q));
                    chk("cpu_err", 64'(cpu_err), 64'(e.err));
                    chk("err_sticky", 64'(err_sticky), 64'(e.sticky));
                    if (e.to) chk("timeout_latency", 64'(cyc - start_cyc), 64'(TIMEOUT + 2));
                    else      chk("ack_latency", 64'(cyc - last_busy_cyc), 64'(2));
                end
                last_q = cpu_q;
                last_ack_cyc = cyc;
                have_cur = 1'b0;
            end else begin
                chk("cpu_q_hold", 64'(cpu_q), 64'(last_q));
            end
            prev_start = mu_start;
            prev_ack = cpu_ack;
        end
    end

    task automatic start_req(input logic we, input logic [26:0] a, input logic [31:0] d,
                             input bit stuck, input int dly, input int len, input bit chained);
        exp_t e;
        e.we = we; e.addr = a; e.data = d; e.to = stuck; e.chained = chained;
        if (stuck) begin
            e.q = '0; e.err = 1'b1; sticky_m = 1'b1;
        end else if (we) begin
            ref_mem[a] = d; e.q = d; e.err = 1'b0;
        end else begin
            e.q = ref_mem.exists(a) ? ref_mem[a] : {5'h1B, a}; e.err = 1'b0;
        end
        e.sticky = sticky_m;
        start_q.push_back(e);
        ack_q.push_back(e);
        cfg_stuck = stuck; cfg_dly = dly; cfg_len = len;
        cpu_we = we; cpu_addr = a; cpu_data = d; cpu_req = 1'b1;
    endtask

    task automatic finish_req(input bit keep);
        int n;
        n = 0;
        while (!mu_start && n < 20) begin @(negedge clk); n++; end
        chk("start_seen", 64'(mu_start), 64'(1));
        cpu_addr = 27'($urandom); cpu_data = $urandom; cpu_we = 1'($urandom);
        n = 0;
        while (!cpu_ack && n < 40) begin @(negedge clk); n++; end
        chk("ack_seen", 64'(cpu_ack), 64'(1));
        if (!keep) cpu_req = 1'b0;
    endtask

    task automatic chk_reset_outs();
        chk("rst_cpu_ack", 64'(cpu_ack), 64'(0));
        chk("rst_cpu_err", 64'(cpu_err), 64'(0));
        chk("rst_err_sticky", 64'(err_sticky), 64'(0));
        chk("rst_ready", 64'(ready), 64'(0));
        chk("rst_mu_start", 64'(mu_start), 64'(0));
        chk("rst_mu_we", 64'(mu_we), 64'(0));
        chk("rst_cpu_q", 64'(cpu_q), 64'(0));
        chk("rst_mu_address", 64'(mu_address), 64'(0));
        chk("rst_mu_data", 64'(mu_data), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [26:0] addr_tbl [8];
        int  s0;
        int  n;
        bit  keep;
        bit  prev_keep;
        addr_tbl = '{27'h0, 27'h123, 27'h7FFFFFF, 27'h55, 27'h1000, 27'h3, 27'h4AB_CDE0, 27'h2};

        nreset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_data = '0;
        mu_initDone = 1'b0;
        #3 chk_reset_outs();
        @(negedge clk); @(negedge clk);
        nreset = 1'b1;

        // Init gating, then the directed read.
        ref_mem[27'h123] = 32'hCAFEF00D;
        mu_mem[27'h123]  = 32'hCAFEF00D;
        start_req(1'b0, 27'h123, 32'h0, 1'b0, 0, 3, 1'b0);
        repeat (20) begin
            @(negedge clk);
            chk("init_no_start", 64'(mu_start), 64'(0));
            chk("init_not_ready", 64'(ready), 64'(0));
        end
        mu_initDone = 1'b1;
        s0 = start_cnt;
        @(negedge clk);
        chk("ready_after_init", 64'(ready), 64'(1));
        chk("no_start_yet", 64'(mu_start), 64'(0));
        @(negedge clk);
        chk("start_after_init", 64'(mu_start), 64'(1));
        finish_req(1'b0);
        chk("read_q", 64'(cpu_q), 64'(32'hCAFEF00D));
        chk("read_err", 64'(cpu_err), 64'(0));
        @(negedge clk);
        chk("read_one_start", 64'(start_cnt - s0), 64'(1));

        // Directed write at the top address.
        start_req(1'b1, 27'h7FFFFFF, 32'hA5A5A5A5, 1'b0, 1, 4, 1'b0);
        finish_req(1'b0);
        chk("write_addr_held", 64'(mu_address), 64'(27'h7FFFFFF));
        chk("write_data_held", 64'(mu_data), 64'(32'hA5A5A5A5));
        chk("write_we_held", 64'(mu_we), 64'(1));

        // Timeout with busy stuck low, then a normal access keeps the sticky flag.
        @(negedge clk);
        start_req(1'b0, 27'h55, 32'h0, 1'b1, 0, 1, 1'b0);
        finish_req(1'b0);
        chk("to_err", 64'(cpu_err), 64'(1));
        chk("to_q", 64'(cpu_q), 64'(0));
        chk("to_sticky", 64'(err_sticky), 64'(1));
        @(negedge clk);
        start_req(1'b0, 27'h7FFFFFF, 32'h0, 1'b0, 0, 1, 1'b0);
        finish_req(1'b0);
        chk("sticky_kept", 64'(err_sticky), 64'(1));

        // Back-to-back with cpu_req held through three accesses.
        @(negedge clk);
        s0 = start_cnt;
        start_req(1'b1, 27'h1000, 32'h11112222, 1'b0, 0, 2, 1'b0);
        finish_req(1'b1);
        start_req(1'b0, 27'h1000, 32'h0, 1'b0, 2, 1, 1'b1);
        finish_req(1'b1);
        start_req(1'b0, 27'h123, 32'h0, 1'b0, 0, 4, 1'b1);
        finish_req(1'b0);
        @(negedge clk);
        chk("b2b_starts", 64'(start_cnt - s0), 64'(3));

        // Randomised traffic; initDone drops and ready must stay up.
        mu_initDone = 1'b0;
        prev_keep = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!prev_keep) repeat ($urandom_range(1, 3)) @(negedge clk);
            start_req(1'($urandom), addr_tbl[$urandom_range(0, 7)], $urandom,
                      ($urandom_range(0, 9) == 0), $urandom_range(0, 2), $urandom_range(1, 4), prev_keep);
            keep = ($urandom_range(0, 1) == 1) && (i < 39);
            finish_req(keep);
            prev_keep = keep;
        end
        chk("ready_stays", 64'(ready), 64'(1));

        // Reset in WAIT_DONE.
        mu_initDone = 1'b1;
        @(negedge clk);
        start_req(1'b0, 27'h123, 32'h0, 1'b0, 0, 6, 1'b0);
        n = 0;
        while (!mu_busy && n < 20) begin @(negedge clk); n++; end
        chk("busy_seen", 64'(mu_busy), 64'(1));
        @(negedge clk);
        #2 nreset = 1'b0;
        have_cur = 1'b0;
        #1 chk_reset_outs();
        start_q.delete(); ack_q.delete();
        sticky_m = 1'b0; last_q = '0; cpu_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("no_ack_in_reset", 64'(cpu_ack), 64'(0));
        nreset = 1'b1;
        #1 chk("ready_at_release", 64'(ready), 64'(0));
        @(negedge clk);
        chk("ready_after_release", 64'(ready), 64'(1));
        start_req(1'b0, 27'h1000, 32'h0, 1'b0, 1, 2, 1'b0);
        finish_req(1'b0);
        chk("sticky_cleared", 64'(err_sticky), 64'(0));

        repeat (3) @(negedge clk);
        chk("start_q_empty", 64'(start_q.size()), 64'(0));
        chk("ack_q_empty", 64'(ack_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
